main_fsm: RTL and testbench
===========================

MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk input 1 (rising-edge clock); reset input 1 (synchronous, active-high).
REQ-002 Op input 2: instruction class (00 data-processing, 01 memory, 10 branch, 11 undefined).
REQ-003 Funct input 6: Funct[5] immediate flag, Funct[0] load/store (L) bit.
REQ-004 IRWrite output 1: instruction-register load enable.
REQ-005 AdrSrc output 1: memory address select (0 PC, 1 ALU result).
REQ-006 ALUSrcA output 2: 00 register A, 01 PC, 10 ALU-out register.
REQ-007 ALUSrcB output 2: 00 register B, 01 extended immediate, 10 constant 4.
REQ-008 ResultSrc output 2: 00 ALU-out register, 01 data register, 10 direct ALU result.
REQ-009 ALUOp output 1: 1 = decode ALU operation from Funct; 0 = add.
REQ-010 NextPC, RegW, MemW, Branch outputs 1 each: unconditional write requests, gated downstream by condition logic.
REQ-011 MemReady input 1, present only under MAIN_FSM_WAIT_EN: memory transfer completes this cycle.

Function
REQ-012 States SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, UNKNOWN, with a registered state and Moore outputs only.
REQ-013 FETCH SHALL go to DECODE; outputs: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALUOp=0.
REQ-014 DECODE SHALL go to MEMADR (Op=01), EXECUTER (Op=00, Funct[5]=0), EXECUTEI (Op=00, Funct[5]=1), BRANCH (Op=10), or UNKNOWN (Op=11); outputs: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
REQ-015 MEMADR SHALL go to MEMREAD if Funct[0]=1, else MEMWRITE; outputs: ALUSrcA=00, ALUSrcB=01, ALUOp=0.
REQ-016 MEMREAD SHALL go to MEMWB; outputs: AdrSrc=1, ResultSrc=00.
REQ-017 MEMWB SHALL go to FETCH; outputs: RegW=1, ResultSrc=01.
REQ-018 MEMWRITE SHALL go to FETCH; outputs: MemW=1, AdrSrc=1, ResultSrc=00.
REQ-019 EXECUTER and EXECUTEI SHALL each go to ALUWB; outputs: ALUSrcA=00, ALUOp=1, with ALUSrcB=00 (EXECUTER) or 01 (EXECUTEI).
REQ-020 ALUWB SHALL go to FETCH; outputs: RegW=1, ResultSrc=00.
REQ-021 BRANCH SHALL go to FETCH; outputs: Branch=1, ALUSrcA=10, ALUSrcB=01, ResultSrc=10, ALUOp=0.
REQ-022 UNKNOWN SHALL go to FETCH with all outputs 0.
REQ-023 Any output not listed for a state SHALL be 0, so outputs never carry don't-care values.
REQ-024 Instruction latency SHALL be: LDR 5 cycles, STR 4, data-processing 4, B 3, undefined 3 (without waits).
REQ-025 An illegal state encoding SHALL go to FETCH on the next edge.
REQ-026 Op and Funct SHALL be sampled only in DECODE and MEMADR and ignored in all other states.

Reset
REQ-027 Reset asserted at a clock edge SHALL force state FETCH, regardless of the current state, including mid-instruction.
REQ-028 While reset is held, outputs SHALL be the FETCH values; the first post-reset edge SHALL enter DECODE.

Configuration
REQ-029 With MAIN_FSM_WAIT_EN defined, FETCH, MEMREAD and MEMWRITE SHALL hold state and outputs while MemReady=0 and advance only on MemReady=1.
REQ-030 While MAIN_FSM_WAIT_EN stalls in FETCH, IRWrite and NextPC SHALL be asserted only in the MemReady=1 cycle.
REQ-031 While MAIN_FSM_WAIT_EN stalls in MEMWRITE, MemW SHALL stay asserted.
REQ-032 Without MAIN_FSM_WAIT_EN, the MemReady port SHALL be absent and behaviour SHALL be exactly REQ-012..REQ-026.

Structure
REQ-033 Package main_fsm_pkg SHALL hold the state enum (4-bit encoding), the ALUSrcA/ALUSrcB/ResultSrc code constants and the Op code constants.
REQ-034 Sub-module main_fsm_outdec SHALL map state to the packed control word; next-state logic and the state register SHALL stay in main_fsm.

Verification
REQ-035 Reset, then Op=00, Funct=6'b000000 -> FETCH, DECODE, EXECUTER (ALUSrcB=00, ALUOp=1), ALUWB (RegW=1), FETCH.
REQ-036 Op=01, Funct[0]=1 -> MEMADR, MEMREAD (AdrSrc=1), MEMWB (RegW=1, ResultSrc=01); FETCH 5 cycles after the start.
REQ-037 Op=01, Funct[0]=0 -> MEMADR, MEMWRITE (MemW=1); Op=10 -> BRANCH (Branch=1, ALUSrcA=10).
REQ-038 Op=11 -> UNKNOWN with all outputs 0, then FETCH; Op/Funct toggled in EXECUTER -> path unchanged.
REQ-039 Reset asserted in MEMREAD -> FETCH next cycle with IRWrite=1, NextPC=1.
REQ-040 Under MAIN_FSM_WAIT_EN, MemReady=0 for 3 cycles in FETCH -> state held, IRWrite=0; MemReady=1 -> IRWrite=1 and DECODE next cycle.

Source files
------------

// File: rtl/main_fsm_pkg.sv
// rtl/main_fsm_pkg.sv - state encoding, control word and code constants for main_fsm
package main_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_UNKNOWN  = 4'd10
  } state_t;

  localparam logic [1:0] SRCA_REG    = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_DATA    = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  localparam logic [1:0] OP_DP       = 2'b00;
  localparam logic [1:0] OP_MEM      = 2'b01;
  localparam logic [1:0] OP_BR       = 2'b10;
  localparam logic [1:0] OP_UNDEF    = 2'b11;

  typedef struct packed {
    logic       ir_write;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       alu_op;
    logic       next_pc;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
  } ctrl_t;

endpackage

// File: rtl/main_fsm_outdec.sv
// rtl/main_fsm_outdec.sv - Moore output decode: state to packed control word
module main_fsm_outdec
  import main_fsm_pkg::*;
(
  input  state_t state_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.ir_write   = 1'b1;
        ctrl_o.next_pc    = 1'b1;
        ctrl_o.alu_src_a  = SRCA_PC;
        ctrl_o.alu_src_b  = SRCB_FOUR;
        ctrl_o.result_src = RES_ALU;
      end
      S_DECODE: begin
        ctrl_o.alu_src_a  = SRCA_PC;
        ctrl_o.alu_src_b  = SRCB_FOUR;
        ctrl_o.result_src = RES_ALU;
      end
      S_MEMADR: begin
        ctrl_o.alu_src_a  = SRCA_REG;
        ctrl_o.alu_src_b  = SRCB_IMM;
      end
      S_MEMREAD: begin
        ctrl_o.adr_src    = 1'b1;
        ctrl_o.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        ctrl_o.reg_w      = 1'b1;
        ctrl_o.result_src = RES_DATA;
      end
      S_MEMWRITE: begin
        ctrl_o.mem_w      = 1'b1;
        ctrl_o.adr_src    = 1'b1;
        ctrl_o.result_src = RES_ALUOUT;
      end
      S_EXECUTER: begin
        ctrl_o.alu_src_a  = SRCA_REG;
        ctrl_o.alu_src_b  = SRCB_REG;
        ctrl_o.alu_op     = 1'b1;
      end
      S_EXECUTEI: begin
        ctrl_o.alu_src_a  = SRCA_REG;
        ctrl_o.alu_src_b  = SRCB_IMM;
        ctrl_o.alu_op     = 1'b1;
      end
      S_ALUWB: begin
        ctrl_o.reg_w      = 1'b1;
        ctrl_o.result_src = RES_ALUOUT;
      end
      S_BRANCH: begin
        ctrl_o.branch     = 1'b1;
        ctrl_o.alu_src_a  = SRCA_ALUOUT;
        ctrl_o.alu_src_b  = SRCB_IMM;
        ctrl_o.result_src = RES_ALU;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/main_fsm.sv
// rtl/main_fsm.sv - multicycle processor main control FSM (state register + next state)
// Optional memory wait handshake via MAIN_FSM_WAIT_EN (adds MemReady input).
module main_fsm
  import main_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
`ifdef MAIN_FSM_WAIT_EN
  input  logic       MemReady,
`endif
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch
);

  state_t state_q, state_d;
  ctrl_t  ctrl;
  logic   mem_ready;
  logic   unused_funct;

`ifdef MAIN_FSM_WAIT_EN
  assign mem_ready = MemReady;
`else
  assign mem_ready = 1'b1;
`endif

  assign unused_funct = ^Funct[4:1];

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_UNKNOWN;
        endcase
      end
      S_MEMADR:   state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_UNKNOWN:  state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  main_fsm_outdec u_outdec (
    .state_i (state_q),
    .ctrl_o  (ctrl)
  );

  // A stalled fetch must not load IR or bump PC until the memory delivers.
  assign IRWrite   = ctrl.ir_write & mem_ready;
  assign NextPC    = ctrl.next_pc & mem_ready;
  assign AdrSrc    = ctrl.adr_src;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ResultSrc = ctrl.result_src;
  assign ALUOp     = ctrl.alu_op;
  assign RegW      = ctrl.reg_w;
  assign MemW      = ctrl.mem_w;
  assign Branch    = ctrl.branch;

endmodule

// File: tb/tb_main_fsm.sv
// tb/tb_main_fsm.sv - table-driven self-checking bench for main_fsm
module tb_main_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       MemReady;
  logic       IRWrite, AdrSrc, ALUOp, NextPC, RegW, MemW, Branch;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  main_fsm dut (
    .clk       (clk),
    .reset     (reset),
    .Op        (Op),
    .Funct     (Funct),
`ifdef MAIN_FSM_WAIT_EN
    .MemReady  (MemReady),
`endif
    .IRWrite   (IRWrite),
    .AdrSrc    (AdrSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .ALUOp     (ALUOp),
    .NextPC    (NextPC),
    .RegW      (RegW),
    .MemW      (MemW),
    .Branch    (Branch)
  );

  // {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC, RegW, MemW, Branch}
  localparam logic [12:0] W_FETCH  = {1'b1, 1'b0, 2'b01, 2'b10, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic [12:0] W_DECODE = {1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [12:0] W_MEMADR = {1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [12:0] W_MEMRD  = {1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [12:0] W_MEMWB  = {1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [12:0] W_MEMWR  = {1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [12:0] W_EXER   = {1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [12:0] W_EXEI   = {1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [12:0] W_ALUWB  = {1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [12:0] W_BRANCH = {1'b0, 1'b0, 2'b10, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic [12:0] W_UNK    = 13'd0;
  localparam logic [12:0] W_FSTALL = {1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  typedef struct {
    logic        rst;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [12:0] exp;
    string       name;
  } vec_t;

  vec_t vq[$];

  function automatic logic [12:0] outs();
    return {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC, RegW, MemW, Branch};
  endfunction

  task automatic check(input logic [12:0] act, input logic [12:0] exp, input string name);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [1:0] op, input logic [5:0] f,
                     input logic [12:0] exp, input string name);
    vec_t v;
    v.rst = rst; v.op = op; v.funct = f; v.exp = exp; v.name = name;
    vq.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Counts edges from a FETCH until the next FETCH, bounded.
  task automatic latency(input logic [1:0] op, input logic [5:0] f, input int exp_lat,
                         input string name);
    int n;
    do_reset();
    Op = op; Funct = f;
    #1;
    check(outs(), W_FETCH, {name, "_start"});
    n = 0;
    do begin
      @(negedge clk);
      n++;
      #1;
    end while (outs() !== W_FETCH && n < 10);
    checks++;
    if (n != exp_lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d expected %0d", name, n, exp_lat);
    end
  endtask

  initial begin
    reset = 1'b1; Op = 2'b00; Funct = 6'd0; MemReady = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    check(outs(), W_FETCH, "reset_held");

    add(0, 2'b00, 6'h00, W_FETCH,  "dp_fetch");
    add(0, 2'b00, 6'h00, W_DECODE, "dp_decode");
    add(0, 2'b11, 6'h3F, W_EXER,   "dp_executer_toggle");
    add(0, 2'b10, 6'h3F, W_ALUWB,  "dp_aluwb");
    add(0, 2'b01, 6'h01, W_FETCH,  "ldr_fetch");
    add(0, 2'b01, 6'h01, W_DECODE, "ldr_decode");
    add(0, 2'b01, 6'h01, W_MEMADR, "ldr_memadr");
    add(0, 2'b11, 6'h20, W_MEMRD,  "ldr_memread");
    add(0, 2'b11, 6'h20, W_MEMWB,  "ldr_memwb");
    add(0, 2'b01, 6'h00, W_FETCH,  "str_fetch");
    add(0, 2'b01, 6'h00, W_DECODE, "str_decode");
    add(0, 2'b01, 6'h00, W_MEMADR, "str_memadr");
    add(0, 2'b10, 6'h01, W_MEMWR,  "str_memwrite");
    add(0, 2'b10, 6'h00, W_FETCH,  "b_fetch");
    add(0, 2'b10, 6'h00, W_DECODE, "b_decode");
    add(0, 2'b11, 6'h00, W_BRANCH, "b_branch");
    add(0, 2'b11, 6'h00, W_FETCH,  "und_fetch");
    add(0, 2'b11, 6'h00, W_DECODE, "und_decode");
    add(0, 2'b00, 6'h20, W_UNK,    "und_unknown");
    add(0, 2'b00, 6'h20, W_FETCH,  "dpi_fetch");
    add(0, 2'b00, 6'h20, W_DECODE, "dpi_decode");
    add(0, 2'b00, 6'h20, W_EXEI,   "dpi_executei");
    add(0, 2'b01, 6'h01, W_ALUWB,  "dpi_aluwb");
    add(0, 2'b01, 6'h01, W_FETCH,  "rst_fetch");
    add(0, 2'b01, 6'h01, W_DECODE, "rst_decode");
    add(0, 2'b01, 6'h01, W_MEMADR, "rst_memadr");
    add(1, 2'b01, 6'h01, W_MEMRD,  "rst_in_memread");
    add(1, 2'b01, 6'h01, W_FETCH,  "rst_held_1");
    add(0, 2'b01, 6'h01, W_FETCH,  "rst_held_2");
    add(0, 2'b01, 6'h01, W_DECODE, "rst_release_decode");

    // Inputs are driven after the falling edge and outputs sampled 1 ns later.
    reset = 1'b0;
    foreach (vq[i]) begin
      if (i != 0) @(negedge clk);
      reset = vq[i].rst; Op = vq[i].op; Funct = vq[i].funct;
      #1;
      check(outs(), vq[i].exp, vq[i].name);
    end

    latency(2'b01, 6'h01, 5, "ldr");
    latency(2'b01, 6'h00, 4, "str");
    latency(2'b00, 6'h00, 4, "dp");
    latency(2'b10, 6'h00, 3, "b");
    latency(2'b11, 6'h00, 3, "und");

`ifdef MAIN_FSM_WAIT_EN
    do_reset();
    Op = 2'b01; Funct = 6'h00;
    MemReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check(outs(), W_FSTALL, "wait_fetch_stall");
      @(negedge clk);
    end
    MemReady = 1'b1;
    #1;
    check(outs(), W_FETCH, "wait_fetch_ready");
    @(negedge clk);
    #1;
    check(outs(), W_DECODE, "wait_decode");
    @(negedge clk);
    @(negedge clk);
    MemReady = 1'b0;
    #1;
    check(outs(), W_MEMWR, "wait_memwrite_enter");
    @(negedge clk);
    #1;
    check(outs(), W_MEMWR, "wait_memwrite_hold");
    MemReady = 1'b1;
    @(negedge clk);
    #1;
    check(outs(), W_FETCH, "wait_memwrite_done");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
